// File: rtl/stack.sv
// LIFO of (x, y) coordinate pairs with a registered pop result and an error flag.
// Accepts one push or one pop per clock; push wins when both are requested.
module stack #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 256,
    parameter int PTR_W = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] xIn,
    input  logic [WIDTH-1:0] yIn,
    output logic [WIDTH-1:0] xOut,
    output logic [WIDTH-1:0] yOut,
    output logic             fail
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [2*WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   cnt;
    logic [PTR_W-1:0]   cnt_dec;
    logic               empty;
    logic               full;
    logic               do_push;
    logic               do_pop;

    always_comb begin
        cnt_dec = cnt - PTR_W'(1);
        empty   = (cnt == '0);
        full    = (cnt == PTR_W'(DEPTH));
        do_push = push && !full;
        do_pop  = !push && pop && !empty;
    end

    // Storage has no reset; only entries below cnt are ever read.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[cnt[AW-1:0]] <= {xIn, yIn};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            xOut <= '0;
            yOut <= '0;
            fail <= 1'b0;
        end else if (push) begin
            if (full) begin
                fail <= 1'b1;
            end else begin
                cnt  <= cnt + PTR_W'(1);
                fail <= 1'b0;
            end
        end else if (pop) begin
            if (empty) begin
                fail <= 1'b1;
            end else begin
                {xOut, yOut} <= mem[cnt_dec[AW-1:0]];
                cnt          <= cnt_dec;
                fail         <= 1'b0;
            end
        end
    end

    logic unused;
    assign unused = do_pop;

endmodule

// File: tb/tb_stack.sv
// Directed bench for stack: a reference LIFO predicts each edge's outputs,
// predictions are queued on drive and popped for comparison after the edge.
module tb_stack;

    localparam int W = 4;
    localparam int D = 256;
    localparam int P = 9;

    logic         clk  = 1'b0;
    logic         rst  = 1'b0;
    logic         push = 1'b0;
    logic         pop  = 1'b0;
    logic [W-1:0] x_in = '0;
    logic [W-1:0] y_in = '0;
    logic [W-1:0] x_out;
    logic [W-1:0] y_out;
    logic         fail;

    stack #(.WIDTH(W), .DEPTH(D), .PTR_W(P)) dut (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .pop  (pop),
        .xIn  (x_in),
        .yIn  (y_in),
        .xOut (x_out),
        .yOut (y_out),
        .fail (fail)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    logic [2*W-1:0] model [$];
    logic [2*W:0]   sb    [$];
    logic [W-1:0]   ex    = '0;
    logic [W-1:0]   ey    = '0;
    logic           ef    = 1'b0;

    task automatic check(input string tag, input logic [2*W:0] obs, input logic [2*W:0] exp_v);
        compared++;
        assert (obs === exp_v) else begin
            mismatched++;
            $error("FAIL %s: observed {x,y,fail}=%h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic step(input logic p, input logic q, input logic [W-1:0] xv,
                        input logic [W-1:0] yv, input string tag);
        logic [2*W:0] e;
        @(negedge clk);
        push = p;
        pop  = q;
        x_in = xv;
        y_in = yv;
        if (p) begin
            if (model.size() == D) ef = 1'b1;
            else begin
                model.push_back({xv, yv});
                ef = 1'b0;
            end
        end else if (q) begin
            if (model.size() == 0) ef = 1'b1;
            else begin
                {ex, ey} = model.pop_back();
                ef = 1'b0;
            end
        end
        sb.push_back({ex, ey, ef});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check(tag, {x_out, y_out, fail}, e);
    endtask

    task automatic apply_reset(input logic keep_pop);
        @(negedge clk);
        push = 1'b0;
        pop  = keep_pop;
        #2 rst = 1'b0;
        #1;
        model.delete();
        ex = '0;
        ey = '0;
        ef = 1'b0;
        check("reset_async", {x_out, y_out, fail}, '0);
        @(posedge clk);
        #1;
        check("reset_hold", {x_out, y_out, fail}, '0);
        @(negedge clk);
        pop = 1'b0;
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        apply_reset(1'b0);
        step(1'b0, 1'b1, 4'h0, 4'h0, "empty_pop");

        step(1'b1, 1'b0, 4'h1, 4'h0, "push_10");
        step(1'b1, 1'b0, 4'h0, 4'h1, "push_01");
        step(1'b0, 1'b1, 4'h0, 4'h0, "pop_01");
        step(1'b0, 1'b1, 4'h0, 4'h0, "pop_10");
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b1, 4'h0, 4'h0, "underflow");
        step(1'b1, 1'b0, 4'h5, 4'hA, "push_5A");
        step(1'b0, 1'b1, 4'h0, 4'h0, "pop_5A");
        step(1'b0, 1'b0, 4'h0, 4'h0, "idle_hold");

        for (int i = 0; i < D; i++)
            step(1'b1, 1'b0, W'(i % 16), W'(i / 16), "fill");
        step(1'b1, 1'b0, 4'hF, 4'hF, "overflow");
        step(1'b0, 1'b0, 4'h0, 4'h0, "overflow_hold");
        for (int i = 0; i < D; i++)
            step(1'b0, 1'b1, 4'h0, 4'h0, "drain");
        step(1'b0, 1'b1, 4'h0, 4'h0, "drain_underflow");

        step(1'b1, 1'b0, 4'h3, 4'h4, "push_34");
        step(1'b1, 1'b1, 4'h7, 4'h8, "simul_push_pop");
        step(1'b0, 1'b1, 4'h0, 4'h0, "pop_78");
        step(1'b0, 1'b1, 4'h0, 4'h0, "pop_34");
        step(1'b0, 1'b1, 4'h0, 4'h0, "simul_underflow");

        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b0, W'(i + 9), W'(i + 2), "pre_reset_push");
        step(1'b0, 1'b1, 4'h0, 4'h0, "pre_reset_pop");
        apply_reset(1'b1);
        step(1'b0, 1'b1, 4'h0, 4'h0, "post_reset_pop");
        step(1'b1, 1'b0, 4'h6, 4'h2, "post_reset_push");
        step(1'b0, 1'b1, 4'h0, 4'h0, "post_reset_pop_62");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
